// File: rtl/store_queue.sv
// store_queue: circular in-order store buffer between dispatch, the store FU,
// ROB commit marks and the data cache write port.
// Optional store-to-load forwarding port is built when STORE_FWD_EN is defined.
module store_queue #(
  parameter int N           = 2,
  parameter int SQ_ENTRIES  = 8,
  parameter int SQ_IDX_BITS = $clog2(SQ_ENTRIES),
  parameter int XLEN        = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               dispatch_valid,
  output logic [N*SQ_IDX_BITS-1:0]   alloc_index,
  output logic                       sq_full,
  output logic                       sq_empty,
  input  logic                       exec_valid,
  input  logic [SQ_IDX_BITS-1:0]     exec_index,
  input  logic [XLEN-1:0]            exec_addr,
  input  logic [XLEN-1:0]            exec_data,
  input  logic [1:0]                 exec_size,
  input  logic [N-1:0]               ready_valid,
  input  logic [N*SQ_IDX_BITS-1:0]   ready_index,
  input  logic                       branch_mispredict,
  output logic                       mem_req_valid,
  output logic [XLEN-1:0]            mem_req_addr,
  output logic [XLEN-1:0]            mem_req_data,
  output logic [1:0]                 mem_req_size,
`ifdef STORE_FWD_EN
  input  logic                       ld_valid,
  input  logic [XLEN-1:0]            ld_addr,
  input  logic [SQ_IDX_BITS-1:0]     ld_sq_tail,
  output logic                       fwd_hit,
  output logic [XLEN-1:0]            fwd_data,
`endif
  input  logic                       mem_req_ready
);

  typedef logic [SQ_IDX_BITS-1:0] idx_t;
  typedef logic [SQ_IDX_BITS:0]   cnt_t;

  logic [SQ_ENTRIES-1:0]            valid_q, valid_d, exec_q, exec_d, rdy_q, rdy_d;
  logic [SQ_ENTRIES-1:0][XLEN-1:0]  addr_q, addr_d, data_q, data_d;
  logic [SQ_ENTRIES-1:0][1:0]       size_q, size_d;
  idx_t                             head_q, head_d, tail_q, tail_d;
  cnt_t                             count_q, count_d;
  logic                             fire;
  idx_t                             slot, ridx;
  cnt_t                             nalloc, nsurv;

  assign sq_full  = (SQ_ENTRIES - int'(count_q)) < N;
  assign sq_empty = (count_q == '0);

  // Slot i of this cycle's dispatch group lands at tail+i.
  for (genvar g = 0; g < N; g++) begin : g_alloc
    assign alloc_index[g*SQ_IDX_BITS +: SQ_IDX_BITS] = tail_q + idx_t'(g);
  end

  assign mem_req_valid = valid_q[head_q] & rdy_q[head_q] & exec_q[head_q];
  assign mem_req_addr  = addr_q[head_q];
  assign mem_req_data  = data_q[head_q];
  assign mem_req_size  = size_q[head_q];
  assign fire          = mem_req_valid & mem_req_ready;

  // Next state: exec write, ready marks, drain, then either flush or dispatch.
  always_comb begin
    valid_d = valid_q;
    exec_d  = exec_q;
    rdy_d   = rdy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    nalloc  = '0;
    nsurv   = '0;
    slot    = '0;
    ridx    = '0;

    if (exec_valid) begin
      addr_d[exec_index] = exec_addr;
      data_d[exec_index] = exec_data;
      size_d[exec_index] = exec_size;
      exec_d[exec_index] = 1'b1;
    end

    // Marks are idempotent; marks on free entries are dropped.
    for (int i = 0; i < N; i++) begin
      ridx = ready_index[i*SQ_IDX_BITS +: SQ_IDX_BITS];
      if (ready_valid[i] && valid_q[ridx]) rdy_d[ridx] = 1'b1;
    end

    if (fire) begin
      valid_d[head_q] = 1'b0;
      exec_d[head_q]  = 1'b0;
      rdy_d[head_q]   = 1'b0;
      head_d          = head_q + idx_t'(1);
    end

    if (branch_mispredict) begin
      // Only marked (non-speculative) stores survive; they form a run from head.
      for (int e = 0; e < SQ_ENTRIES; e++) begin
        if (!rdy_d[e]) begin
          valid_d[e] = 1'b0;
          exec_d[e]  = 1'b0;
        end
        nsurv = nsurv + cnt_t'(valid_d[e] & rdy_d[e]);
      end
      tail_d  = head_d + idx_t'(nsurv);
      count_d = nsurv;
    end else begin
      if (!sq_full) begin
        for (int i = 0; i < N; i++) begin
          if (dispatch_valid[i]) begin
            slot          = tail_q + idx_t'(i);
            valid_d[slot] = 1'b1;
            exec_d[slot]  = 1'b0;
            rdy_d[slot]   = 1'b0;
            nalloc        = nalloc + cnt_t'(1);
          end
        end
      end
      tail_d  = tail_q + idx_t'(nalloc);
      count_d = count_q + nalloc - cnt_t'(fire);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      exec_q  <= '0;
      rdy_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      exec_q  <= exec_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef STORE_FWD_EN
  idx_t fdist, fidx;

  // Scan older stores head..ld_sq_tail-1 in age order; the last (youngest) match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fidx     = '0;
    fdist    = ld_sq_tail - head_q;
    if (ld_valid) begin
      for (int k = 0; k < SQ_ENTRIES; k++) begin
        fidx = head_q + idx_t'(k);
        if (idx_t'(k) < fdist && valid_q[fidx] && exec_q[fidx] && size_q[fidx] == 2'd2 &&
            addr_q[fidx][XLEN-1:2] == ld_addr[XLEN-1:2]) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fidx];
        end
      end
    end
  end
`endif

endmodule
